// File: rtl/diglock_access_ctrl.sv
// Access sequencer for the digital lock: grants timed open, timed deny, or alarm lockout after MAX_FAIL misses.
// Latency: outputs assert on the first clk edge after the req_access rise cycle; each pulse is exactly N cycles.
// Backpressure: none; requests arriving outside IDLE are dropped, and a held request never retriggers.
module diglock_access_ctrl #(
    parameter int MAX_FAIL       = 3,
    parameter int OPEN_CYCLES    = 50000000,
    parameter int DENY_CYCLES    = 25000000,
    parameter int LOCKOUT_CYCLES = 500000000,
    parameter int FCW            = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_access,
    input  logic           first_four_match,
    input  logic           last_four_match,
    output logic           lock_open,
    output logic           deny_access,
    output logic           alarm,
    output logic           busy,
    output logic [FCW-1:0] fail_count
);

    localparam int MAX_AB  = (OPEN_CYCLES > DENY_CYCLES) ? OPEN_CYCLES : DENY_CYCLES;
    localparam int MAX_CYC = (MAX_AB > LOCKOUT_CYCLES) ? MAX_AB : LOCKOUT_CYCLES;
    localparam int TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [TW-1:0]  OPEN_LOAD  = TW'(OPEN_CYCLES - 1);
    localparam logic [TW-1:0]  DENY_LOAD  = TW'(DENY_CYCLES - 1);
    localparam logic [TW-1:0]  LOCK_LOAD  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [FCW-1:0] FAIL_LAST  = FCW'(MAX_FAIL - 1);
    localparam logic [FCW-1:0] FAIL_LIMIT = FCW'(MAX_FAIL);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        OPEN    = 2'd1,
        DENY    = 2'd2,
        LOCKOUT = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [TW-1:0]  timer, timer_nxt;
    logic [FCW-1:0] fail_nxt;
    logic           req_q;
    logic           rise;

    assign rise = req_access & ~req_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            timer       <= '0;
            fail_count  <= '0;
            req_q       <= 1'b0;
            lock_open   <= 1'b0;
            deny_access <= 1'b0;
            alarm       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            fail_count  <= fail_nxt;
            req_q       <= req_access;
            // Outputs are registered copies of the decode of the state being entered.
            lock_open   <= (state_nxt == OPEN);
            deny_access <= (state_nxt == DENY) || (state_nxt == LOCKOUT);
            alarm       <= (state_nxt == LOCKOUT);
            busy        <= (state_nxt != IDLE);
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        fail_nxt  = fail_count;
        case (state)
            IDLE: begin
                if (rise) begin
                    if (first_four_match && last_four_match) begin
                        state_nxt = OPEN;
                        timer_nxt = OPEN_LOAD;
                        fail_nxt  = '0;
                    end else if (fail_count == FAIL_LAST) begin
                        state_nxt = LOCKOUT;
                        timer_nxt = LOCK_LOAD;
                        fail_nxt  = FAIL_LIMIT;
                    end else begin
                        state_nxt = DENY;
                        timer_nxt = DENY_LOAD;
                        fail_nxt  = fail_count + 1'b1;
                    end
                end
            end
            OPEN, DENY, LOCKOUT: begin
                if (timer == '0) begin
                    state_nxt = IDLE;
                    if (state == LOCKOUT) begin
                        fail_nxt = '0;
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                timer_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_diglock_access_ctrl.sv
// Randomized and directed bench for diglock_access_ctrl against a remaining-cycles reference model.
module tb_diglock_access_ctrl;

    localparam int MAX_FAIL = 3;
    localparam int OPEN_C   = 8;
    localparam int DENY_C   = 4;
    localparam int LOCK_C   = 16;
    localparam int FCW      = 4;

    localparam int M_IDLE = 0;
    localparam int M_OPEN = 1;
    localparam int M_DENY = 2;
    localparam int M_LOCK = 3;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           req_access = 1'b0;
    logic           ffm = 1'b0;
    logic           lfm = 1'b0;
    logic           lock_open, deny_access, alarm, busy;
    logic [FCW-1:0] fail_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: current mode, cycles of it still to be shown, failure tally.
    int   m_mode  = M_IDLE;
    int   m_left  = 0;
    int   m_fails = 0;
    logic m_req_prev = 1'b0;

    logic [7:0] obs;
    logic [7:0] exp_v;

    diglock_access_ctrl #(
        .MAX_FAIL(MAX_FAIL), .OPEN_CYCLES(OPEN_C), .DENY_CYCLES(DENY_C),
        .LOCKOUT_CYCLES(LOCK_C), .FCW(FCW)
    ) dut (
        .clk(clk), .rst(rst), .req_access(req_access),
        .first_four_match(ffm), .last_four_match(lfm),
        .lock_open(lock_open), .deny_access(deny_access), .alarm(alarm),
        .busy(busy), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_mode     <= M_IDLE;
            m_left     <= 0;
            m_fails    <= 0;
            m_req_prev <= 1'b0;
        end else begin
            m_req_prev <= req_access;
            if (m_mode == M_IDLE) begin
                if (req_access && !m_req_prev) begin
                    if (ffm && lfm) begin
                        m_mode <= M_OPEN; m_left <= OPEN_C; m_fails <= 0;
                    end else if (m_fails + 1 >= MAX_FAIL) begin
                        m_mode <= M_LOCK; m_left <= LOCK_C; m_fails <= MAX_FAIL;
                    end else begin
                        m_mode <= M_DENY; m_left <= DENY_C; m_fails <= m_fails + 1;
                    end
                end
            end else if (m_left == 1) begin
                if (m_mode == M_LOCK) m_fails <= 0;
                m_mode <= M_IDLE;
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
            end
        end
    end

    assign obs   = {lock_open, deny_access, alarm, busy, fail_count};
    assign exp_v = {m_mode == M_OPEN, (m_mode == M_DENY) || (m_mode == M_LOCK),
                    m_mode == M_LOCK, m_mode != M_IDLE, 4'(m_fails)};

    // Drive one cycle of inputs, let the posedge consume them, return at the following negedge.
    task automatic cyc(input logic r, input logic f, input logic l);
        req_access = r;
        ffm        = f;
        lfm        = l;
        @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", obs, 8'h00);
        end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL reset_release cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_open;
        int opens;
        int busies;
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (lock_open !== 1'b1 || fail_count !== 4'd0) begin
            failures++;
            $display("FAIL open_latency lock_open=%b fail_count=%0d exp 1/0", lock_open, fail_count);
        end
        opens  = int'(lock_open);
        busies = int'(busy);
        for (int i = 0; i < 12; i++) begin
            cyc(1'b0, 1'b1, 1'b1);
            opens  += int'(lock_open);
            busies += int'(busy);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL open_trace cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        checks++;
        if (opens != OPEN_C || busies != OPEN_C) begin
            failures++;
            $display("FAIL open_width open=%0d busy=%0d exp=%0d", opens, busies, OPEN_C);
        end
    endtask

    task automatic test_lockout;
        int dn;
        int al;
        for (int k = 1; k <= MAX_FAIL; k++) begin
            cyc(1'b1, 1'b0, 1'b1);
            checks++;
            if (fail_count !== 4'(k)) begin
                failures++;
                $display("FAIL lockout_count attempt=%0d got=%0d exp=%0d", k, fail_count, k);
            end
            dn = int'(deny_access);
            al = int'(alarm);
            for (int i = 0; i < 20; i++) begin
                cyc(1'b0, 1'b0, 1'b0);
                dn += int'(deny_access);
                al += int'(alarm);
                checks++;
                if (obs !== exp_v) begin
                    failures++;
                    $display("FAIL lockout_trace attempt=%0d cyc=%0d got=%h exp=%h", k, i, obs, exp_v);
                end
            end
            checks++;
            if ((k < MAX_FAIL && (dn != DENY_C || al != 0)) ||
                (k == MAX_FAIL && (dn != LOCK_C || al != LOCK_C))) begin
                failures++;
                $display("FAIL lockout_width attempt=%0d deny=%0d alarm=%0d", k, dn, al);
            end
        end
        checks++;
        if (fail_count !== 4'd0) begin
            failures++;
            $display("FAIL lockout_clear got=%0d exp=0", fail_count);
        end
    endtask

    task automatic test_fail_reset;
        for (int k = 0; k < 2; k++) begin
            cyc(1'b1, 1'b1, 1'b0);
            for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);
        end
        checks++;
        if (fail_count !== 4'd2) begin
            failures++;
            $display("FAIL failreset_two got=%0d exp=2", fail_count);
        end
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (lock_open !== 1'b1 || fail_count !== 4'd0) begin
            failures++;
            $display("FAIL failreset_open lock_open=%b fail_count=%0d exp 1/0", lock_open, fail_count);
        end
        for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if ({deny_access, alarm, fail_count} !== {1'b1, 1'b0, 4'd1}) begin
            failures++;
            $display("FAIL failreset_deny deny=%b alarm=%b fail_count=%0d exp 1/0/1",
                     deny_access, alarm, fail_count);
        end
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL failreset_trace cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_hold;
        int opens;
        int starts;
        logic prev;
        opens = 0; starts = 0; prev = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc((i < 30) ? 1'b1 : 1'b0, 1'b1, 1'b1);
            opens += int'(lock_open);
            if (lock_open && !prev) starts++;
            prev = lock_open;
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL hold_trace cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        checks++;
        if (opens != OPEN_C || starts != 1) begin
            failures++;
            $display("FAIL hold_once open=%0d starts=%0d exp=%0d/1", opens, starts, OPEN_C);
        end
        opens = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc((i == 0 || i == 3) ? 1'b1 : 1'b0, 1'b1, 1'b1);
            opens += int'(lock_open);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL repulse_trace cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
        checks++;
        if (opens != OPEN_C) begin
            failures++;
            $display("FAIL repulse_ignored open=%0d exp=%0d", opens, OPEN_C);
        end
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < MAX_FAIL; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (k < MAX_FAIL - 1) for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        checks++;
        if ({alarm, deny_access, fail_count} !== {1'b1, 1'b1, 4'd3}) begin
            failures++;
            $display("FAIL areset_pre alarm=%b deny=%b fail_count=%0d exp 1/1/3",
                     alarm, deny_access, fail_count);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (obs !== 8'h00) begin
            failures++;
            $display("FAIL areset_async got=%h exp=%h", obs, 8'h00);
        end
        @(negedge clk);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if (lock_open !== 1'b1) begin
            failures++;
            $display("FAIL areset_reopen lock_open=%b exp=1", lock_open);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL areset_trace cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_sample_cycle;
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1);
        checks++;
        if ({lock_open, deny_access} !== 2'b01) begin
            failures++;
            $display("FAIL sample_wrong open=%b deny=%b exp 0/1", lock_open, deny_access);
        end
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b0, 1'b0);
        checks++;
        if ({lock_open, deny_access, fail_count} !== {1'b1, 1'b0, 4'd0}) begin
            failures++;
            $display("FAIL sample_right open=%b deny=%b fail_count=%0d exp 1/0/0",
                     lock_open, deny_access, fail_count);
        end
        for (int i = 0; i < 10; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL sample_trace cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_random;
        logic r;
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 3) == 0) ? ~req_access : req_access;
            if (i % 700 == 350) begin
                #2 rst = 1'b0;
                #1 rst = 1'b1;
            end
            cyc(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL random_trace cyc=%0d got=%h exp=%h", i, obs, exp_v);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_open();
        test_lockout();
        test_fail_reset();
        test_hold();
        test_async_reset();
        test_sample_cycle();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
